// File: rtl/bcd_cmp_pkg.sv
// Shared definitions for the BCD compare arbiter: FSM state encoding,
// operand geometry and a BCD digit validity helper.
package bcd_cmp_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned DIG_W      = 4;
  localparam int unsigned BCD_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    ACK  = 2'd2
  } state_e;

  // True when every nibble of v is a legal decimal digit (0..9).
  function automatic logic bcd_is_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (v[i*DIG_W +: DIG_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_comparator_4digits.sv
// Four-digit packed-BCD magnitude comparator (combinational).
// Ports:
//   a, b    : operands, digit 3 in [15:12]
//   a_ge_b  : 1 when a >= b, scanning digits most significant first
module bcd_comparator_4digits
  import bcd_cmp_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  output logic             a_ge_b
);

  // First differing digit from the top decides; all digits equal gives ge.
  always_comb begin
    logic decided;
    decided = 1'b0;
    a_ge_b  = 1'b1;
    for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
      if (!decided && (a[i*DIG_W +: DIG_W] != b[i*DIG_W +: DIG_W])) begin
        a_ge_b  = (a[i*DIG_W +: DIG_W] > b[i*DIG_W +: DIG_W]);
        decided = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_cmp_arbiter.sv
// Two-requester round-robin arbiter in front of one shared BCD comparator.
// Each transaction runs IDLE -> CMP -> ACK: the winner's operands are
// latched leaving IDLE, the result is registered leaving CMP, and a one-cycle
// ack is returned to the owner in ACK.
// Optional feature: define BCD_DIGIT_CHECK_EN to flag non-decimal nibbles
// (err=1, ge forced 0); otherwise err is tied low.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req0/a0/b0          : requester 0 request and operands
//   req1/a1/b1          : requester 1 request and operands
//   ack0, ack1          : one-cycle completion pulse to the owner
//   ge, err             : result, valid while ack0 or ack1 is high
//   busy                : high outside IDLE
//   owner               : requester currently (or last) served
//   svc_cnt0, svc_cnt1  : wrapping completed-transaction counters
module bcd_cmp_arbiter
  import bcd_cmp_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [BCD_W-1:0] a0,
  input  logic [BCD_W-1:0] b0,
  input  logic             req1,
  input  logic [BCD_W-1:0] a1,
  input  logic [BCD_W-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             ge,
  output logic             err,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] svc_cnt0,
  output logic [CNT_W-1:0] svc_cnt1
);

  state_e           r_state;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_ge;
  logic             r_err;
  logic             r_busy;
  logic             r_owner;
  logic             r_last_owner;
  logic [BCD_W-1:0] r_a;
  logic [BCD_W-1:0] r_b;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_grant;
  logic             w_a_ge_b;
  logic             w_ge_res;
  logic             w_err_res;

  // A lone request wins; on a tie the requester not served last goes next.
  assign w_grant = (req0 && req1) ? ~r_last_owner : req1;

  bcd_comparator_4digits u_cmp (
    .a      (r_a),
    .b      (r_b),
    .a_ge_b (w_a_ge_b)
  );

`ifdef BCD_DIGIT_CHECK_EN
  // Any non-decimal nibble in either latched operand poisons the result.
  assign w_err_res = ~(bcd_is_valid(r_a) & bcd_is_valid(r_b));
  assign w_ge_res  = w_a_ge_b & ~w_err_res;
`else
  assign w_err_res = 1'b0;
  assign w_ge_res  = w_a_ge_b;
`endif

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_ge         <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_state <= CMP;
            r_busy  <= 1'b1;
            r_owner <= w_grant;
            r_a     <= w_grant ? a1 : a0;
            r_b     <= w_grant ? b1 : b0;
          end
        end
        CMP: begin
          r_state <= ACK;
          r_ge    <= w_ge_res;
          r_err   <= w_err_res;
          r_ack0  <= ~r_owner;
          r_ack1  <= r_owner;
        end
        ACK: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_ack0       <= 1'b0;
          r_ack1       <= 1'b0;
          r_last_owner <= r_owner;
          if (r_owner) r_cnt1 <= r_cnt1 + CNT_W'(1);
          else         r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign ge       = r_ge;
  assign err      = r_err;
  assign busy     = r_busy;
  assign owner    = r_owner;
  assign svc_cnt0 = r_cnt0;
  assign svc_cnt1 = r_cnt1;

endmodule
